// File: rtl/udp_axis_master_pkg.sv
// Shared types and constants for the multi-channel UDP-to-AXI-Stream master.
// Holds the FSM state encoding, ack status codes and the ack datagram length.
package udp_axis_master_pkg;

  typedef enum logic [2:0] {
    RX_HEADER,
    RX_ID,
    RX_DATA,
    RX_DISCARD,
    TX_HEADER,
    TX_PAYLOAD
  } state_t;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_SHORT  = 8'h01;
  localparam logic [7:0] ST_RX_ERR = 8'h02;

  // UDP length of an ack: 8-byte UDP header + ID + status + 16-bit count.
  function automatic logic [15:0] ack_len(input int unsigned id_bytes);
    return 16'(8 + id_bytes + 3);
  endfunction

endpackage

// File: rtl/udp_axis_master_mc_if.sv
// Bus interfaces between the UDP stack, this block and the application sinks.
// AXI-Stream byte bus plus inbound and outbound UDP header channels.
interface axis_bus #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 4
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;
  logic [DEST_W-1:0] tdest;

  modport transmitter (output tdata, tvalid, tlast, tuser, tdest, input tready);
  modport receiver    (input tdata, tvalid, tlast, tuser, output tready);
endinterface

interface udp_rx_hdr_bus;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [15:0] src_port;
  logic [15:0] dst_port;

  modport source (output hdr_valid, src_ip, dst_ip, src_port, dst_port, input hdr_ready);
  modport sink   (input hdr_valid, src_ip, dst_ip, src_port, dst_port, output hdr_ready);
endinterface

interface udp_tx_hdr_bus;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [5:0]  dscp;
  logic [1:0]  ecn;
  logic [7:0]  ttl;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic [15:0] src_port;
  logic [15:0] dst_port;
  logic [15:0] length;
  logic [15:0] checksum;

  modport source (output hdr_valid, dscp, ecn, ttl, src_ip, dst_ip, src_port, dst_port,
                  length, checksum, input hdr_ready);
  modport sink   (input hdr_valid, dscp, ecn, ttl, src_ip, dst_ip, src_port, dst_port,
                  length, checksum, output hdr_ready);
endinterface

// File: rtl/udp_axis_master_mc_ack.sv
// Ack payload serializer: snapshots ID/status/count on start and emits
// ID bytes LSB first, then status, count[7:0], count[15:8], with tlast on the final byte.
module udp_ack_serializer
  import udp_axis_master_pkg::*;
#(
  parameter int ID_BYTES = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*ID_BYTES-1:0] id,
  input  logic [7:0]            status,
  input  logic [15:0]           count,
  output logic                  done,
  axis_bus.transmitter          ack_axis
);

  localparam int         N_BYTES  = ID_BYTES + 3;
  localparam logic [3:0] LAST_IDX = 4'(N_BYTES - 1);

  logic                   busy;
  logic [3:0]             idx;
  logic [8*N_BYTES-1:0]   snap;
  logic                   at_last;

  assign at_last          = (idx == LAST_IDX);
  assign ack_axis.tvalid  = busy;
  assign ack_axis.tlast   = busy && at_last;
  assign ack_axis.tuser   = 1'b0;
  assign ack_axis.tdest   = '0;
  assign done             = busy && ack_axis.tready && at_last;

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    ack_axis.tdata = '0;
    for (int k = 0; k < N_BYTES; k++) begin
      if (idx == 4'(k)) ack_axis.tdata = snap[8*k +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments and a synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      idx  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      idx  <= '0;
    end else if (busy && ack_axis.tready) begin
      if (at_last) busy <= 1'b0;
      else         idx  <= idx + 4'd1;
    end
  end

  // NOTE: payload snapshot is not reset; busy gates it, so its power-up value is never seen.
  always_ff @(posedge clk) begin
    if (start) snap <= {count, status, id};
  end

endmodule

// File: rtl/udp_axis_master_mc.sv
// Multi-channel UDP-to-AXI-Stream master: strips a little-endian transfer ID, forwards the
// payload with tdest = channel, and answers each accepted datagram with a status/count ack.
module udp_axis_master_mc
  import udp_axis_master_pkg::*;
#(
  parameter int UDP_PORT_BASE = 4321,
  parameter int NUM_CHANNELS  = 4,
  parameter int ID_BYTES      = 6,
  parameter int ACK_TTL       = 64,
  parameter int DEST_W        = 4
) (
  input  logic          clk,
  input  logic          reset,
  udp_rx_hdr_bus.sink   udp_rx_header_if,
  axis_bus.receiver     udp_rx_payload_if,
  udp_tx_hdr_bus.source udp_tx_header_if,
  axis_bus.transmitter  udp_tx_payload_if,
  axis_bus.transmitter  out_axis_if,
  output logic [31:0]   drop_count
);

  localparam int ID_W = 8 * ID_BYTES;

  state_t            state, state_next;
  logic [31:0]       peer_ip, local_ip;
  logic [15:0]       peer_port, local_port;
  logic [15:0]       ch_q, ch_calc;
  logic [ID_W-1:0]   id_q;
  logic [3:0]        byte_idx;
  logic [15:0]       count_q;
  logic [7:0]        status_q;
  logic              ch_hit, hdr_fire, rx_fire, id_last;
  logic              ack_start, ack_done;

  // Unsigned 16-bit difference: ports below the base wrap high and miss.
  assign ch_calc  = udp_rx_header_if.dst_port - 16'(UDP_PORT_BASE);
  assign ch_hit   = ch_calc < 16'(NUM_CHANNELS);
  assign hdr_fire = udp_rx_header_if.hdr_valid && udp_rx_header_if.hdr_ready;
  assign rx_fire  = udp_rx_payload_if.tvalid && udp_rx_payload_if.tready;
  assign id_last  = (byte_idx == 4'(ID_BYTES - 1));

  assign udp_tx_header_if.dscp     = 6'd0;
  assign udp_tx_header_if.ecn      = 2'd0;
  assign udp_tx_header_if.ttl      = 8'(ACK_TTL);
  assign udp_tx_header_if.src_ip   = local_ip;
  assign udp_tx_header_if.dst_ip   = peer_ip;
  assign udp_tx_header_if.src_port = local_port;
  assign udp_tx_header_if.dst_port = peer_port;
  assign udp_tx_header_if.length   = ack_len(ID_BYTES);
  assign udp_tx_header_if.checksum = 16'h0000;

  assign out_axis_if.tdata = udp_rx_payload_if.tdata;
  assign out_axis_if.tlast = udp_rx_payload_if.tlast;
  assign out_axis_if.tuser = udp_rx_payload_if.tuser;
  assign out_axis_if.tdest = DEST_W'(ch_q);

  always_comb begin
    state_next                  = state;
    udp_rx_header_if.hdr_ready  = 1'b0;
    udp_rx_payload_if.tready    = 1'b0;
    out_axis_if.tvalid          = 1'b0;
    udp_tx_header_if.hdr_valid  = 1'b0;
    ack_start                   = 1'b0;
    case (state)
      RX_HEADER: begin
        udp_rx_header_if.hdr_ready = !reset;
        if (hdr_fire) state_next = ch_hit ? RX_ID : RX_DISCARD;
      end
      RX_DISCARD: begin
        udp_rx_payload_if.tready = 1'b1;
        if (rx_fire && udp_rx_payload_if.tlast) state_next = RX_HEADER;
      end
      RX_ID: begin
        udp_rx_payload_if.tready = 1'b1;
        if (rx_fire) begin
          if (udp_rx_payload_if.tlast) state_next = TX_HEADER;
          else if (id_last)            state_next = RX_DATA;
        end
      end
      RX_DATA: begin
        // Zero-bubble pass-through: the sink's ready steers the source directly.
        out_axis_if.tvalid       = udp_rx_payload_if.tvalid;
        udp_rx_payload_if.tready = out_axis_if.tready;
        if (rx_fire && udp_rx_payload_if.tlast) state_next = TX_HEADER;
      end
      TX_HEADER: begin
        udp_tx_header_if.hdr_valid = 1'b1;
        if (udp_tx_header_if.hdr_ready) begin
          ack_start  = 1'b1;
          state_next = TX_PAYLOAD;
        end
      end
      TX_PAYLOAD: begin
        if (ack_done) state_next = RX_HEADER;
      end
      default: state_next = RX_HEADER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RX_HEADER;
      drop_count <= '0;
    end else begin
      state <= state_next;
      if (hdr_fire && !ch_hit && drop_count != 32'hFFFF_FFFF)
        drop_count <= drop_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_fire) begin
      peer_ip    <= udp_rx_header_if.src_ip;
      local_ip   <= udp_rx_header_if.dst_ip;
      peer_port  <= udp_rx_header_if.src_port;
      local_port <= udp_rx_header_if.dst_port;
      ch_q       <= ch_calc;
      id_q       <= '0;
      byte_idx   <= '0;
      count_q    <= '0;
    end
    if (state == RX_ID && rx_fire) begin
      for (int k = 0; k < ID_BYTES; k++) begin
        if (byte_idx == 4'(k)) id_q[8*k +: 8] <= udp_rx_payload_if.tdata;
      end
      byte_idx <= byte_idx + 4'd1;
      if (udp_rx_payload_if.tlast) begin
        status_q <= ST_SHORT;
        count_q  <= '0;
      end
    end
    if (state == RX_DATA && rx_fire) begin
      if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      if (udp_rx_payload_if.tlast)
        status_q <= udp_rx_payload_if.tuser ? ST_RX_ERR : ST_OK;
    end
  end

  udp_ack_serializer #(
    .ID_BYTES (ID_BYTES)
  ) u_ack (
    .clk      (clk),
    .reset    (reset),
    .start    (ack_start),
    .id       (id_q),
    .status   (status_q),
    .count    (count_q),
    .done     (ack_done),
    .ack_axis (udp_tx_payload_if)
  );

endmodule

// File: tb/tb_udp_axis_master_mc.sv
// Directed-vector bench for udp_axis_master_mc: datagram forwarding, port misses,
// short IDs, error flag with sink backpressure, ack stalls and mid-datagram reset.
module tb_udp_axis_master_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] drop_count;

  always #5 clk = ~clk;

  udp_rx_hdr_bus rx_hdr ();
  udp_tx_hdr_bus tx_hdr ();
  axis_bus #(.DATA_W(8), .DEST_W(4)) rx_pay ();
  axis_bus #(.DATA_W(8), .DEST_W(4)) tx_pay ();
  axis_bus #(.DATA_W(8), .DEST_W(4)) out_axis ();

  udp_axis_master_mc #(
    .UDP_PORT_BASE (4321),
    .NUM_CHANNELS  (4),
    .ID_BYTES      (6),
    .ACK_TTL       (64),
    .DEST_W        (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .udp_rx_header_if  (rx_hdr),
    .udp_rx_payload_if (rx_pay),
    .udp_tx_header_if  (tx_hdr),
    .udp_tx_payload_if (tx_pay),
    .out_axis_if       (out_axis),
    .drop_count        (drop_count)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   pay_q[$];
  logic [7:0]   out_data_q[$];
  logic         out_last_q[$];
  logic         out_user_q[$];
  logic [3:0]   out_dest_q[$];
  logic [7:0]   ack_q[$];
  logic         ack_last_q[$];
  int           ack_hdr_cnt;
  int           ack_done_cnt;
  logic [143:0] ack_hdr_word;
  bit           out_ready_mode = 1'b0;

  // Observe handshakes on the falling edge, half a cycle clear of the DUT's active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_axis.tvalid && out_axis.tready) begin
        out_data_q.push_back(out_axis.tdata);
        out_last_q.push_back(out_axis.tlast);
        out_user_q.push_back(out_axis.tuser);
        out_dest_q.push_back(out_axis.tdest);
      end
      if (tx_pay.tvalid && tx_pay.tready) begin
        ack_q.push_back(tx_pay.tdata);
        ack_last_q.push_back(tx_pay.tlast);
        if (tx_pay.tlast) ack_done_cnt++;
      end
      if (tx_hdr.hdr_valid && tx_hdr.hdr_ready) begin
        ack_hdr_cnt++;
        ack_hdr_word = {tx_hdr.src_ip, tx_hdr.dst_ip, tx_hdr.src_port, tx_hdr.dst_port,
                        tx_hdr.ttl, tx_hdr.length, tx_hdr.checksum, tx_hdr.dscp, tx_hdr.ecn};
      end
    end
  end

  initial begin
    out_axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_axis.tready = out_ready_mode ? ~out_axis.tready : 1'b1;
    end
  end

  function automatic logic [127:0] pack_bytes(input logic [7:0] q[$]);
    logic [127:0] r = '0;
    foreach (q[i]) r = {r[119:0], q[i]};
    return r;
  endfunction

  function automatic logic [31:0] pack_bits(input logic q[$]);
    logic [31:0] r = '0;
    foreach (q[i]) r = {r[30:0], q[i]};
    return r;
  endfunction

  task automatic clear_mon();
    out_data_q.delete(); out_last_q.delete(); out_user_q.delete(); out_dest_q.delete();
    ack_q.delete(); ack_last_q.delete();
    ack_hdr_cnt = 0; ack_done_cnt = 0; ack_hdr_word = '0;
  endtask

  task automatic send_hdr(input logic [15:0] port);
    rx_hdr.hdr_valid = 1'b1;
    rx_hdr.src_ip    = 32'hC0A8_0001;
    rx_hdr.dst_ip    = 32'hC0A8_0002;
    rx_hdr.src_port  = 16'd5000;
    rx_hdr.dst_port  = port;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_hdr.hdr_ready) begin
        @(posedge clk); #1;
        rx_hdr.hdr_valid = 1'b0;
        return;
      end
    end
    vectors++; miscompares++;
    $display("FAIL hdr_accept port %0d: hdr_ready=0 after 200 cycles, required 1", port);
    rx_hdr.hdr_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_payload(input bit with_last, input bit err);
    bit accepted;
    for (int i = 0; i < pay_q.size(); i++) begin
      rx_pay.tvalid = 1'b1;
      rx_pay.tdata  = pay_q[i];
      rx_pay.tlast  = with_last && (i == pay_q.size() - 1);
      rx_pay.tuser  = err && rx_pay.tlast;
      accepted = 1'b0;
      for (int j = 0; j < 200; j++) begin
        @(negedge clk);
        if (rx_pay.tready) begin accepted = 1'b1; break; end
      end
      @(posedge clk); #1;
      if (!accepted) begin
        vectors++; miscompares++;
        $display("FAIL rx_accept byte %0d: tready=0 after 200 cycles, required 1", i);
        break;
      end
    end
    rx_pay.tvalid = 1'b0; rx_pay.tlast = 1'b0; rx_pay.tuser = 1'b0;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack_done_cnt > 0) begin
        @(posedge clk); #1;
        return;
      end
    end
    vectors++; miscompares++;
    $display("FAIL ack_done: no ack tlast after 300 cycles, required one");
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({rx_hdr.hdr_ready, tx_hdr.hdr_valid, tx_pay.tvalid, tx_pay.tuser, out_axis.tvalid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: hdr_ready/hdr_valid/tvalid/tuser/out_tvalid=%b required 00000",
               {rx_hdr.hdr_ready, tx_hdr.hdr_valid, tx_pay.tvalid, tx_pay.tuser, out_axis.tvalid});
    end
    vectors++;
    if (drop_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_drop_count: got %0d required 0", drop_count);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (rx_hdr.hdr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_hdr_ready: got %b required 1", rx_hdr.hdr_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_mon();
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
              8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
    send_hdr(16'd4322);
    send_payload(1'b1, 1'b0);
    wait_ack();
    vectors++;
    if (out_data_q.size() !== 10 || pack_bytes(out_data_q) !== 128'hA0A1A2A3A4A5A6A7A8A9) begin
      miscompares++;
      $display("FAIL basic_out_data: got %0d bytes %h required 10 bytes a0a1..a9",
               out_data_q.size(), pack_bytes(out_data_q));
    end
    vectors++;
    if (pack_bits(out_last_q) !== 32'h1) begin
      miscompares++;
      $display("FAIL basic_out_tlast: got %b required only final beat", pack_bits(out_last_q));
    end
    vectors++;
    if (out_dest_q.size() == 0 || out_dest_q.min() != '{4'd1} || out_dest_q.max() != '{4'd1}) begin
      miscompares++;
      $display("FAIL basic_out_tdest: got min/max of %0d beats not all 1, required 1", out_dest_q.size());
    end
    vectors++;
    if (ack_hdr_cnt !== 1 || ack_hdr_word !== {32'hC0A8_0002, 32'hC0A8_0001, 16'd4322, 16'd5000,
                                               8'd64, 16'd17, 16'd0, 6'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL basic_ack_hdr: got cnt %0d word %h required 1 header swapped ttl 64 len 17",
               ack_hdr_cnt, ack_hdr_word);
    end
    vectors++;
    if (ack_q.size() !== 9 || pack_bytes(ack_q) !== 128'h010203040506000A00
        || pack_bits(ack_last_q) !== 32'h1) begin
      miscompares++;
      $display("FAIL basic_ack_payload: got %0d bytes %h last %b required 010203040506000a00",
               ack_q.size(), pack_bytes(ack_q), pack_bits(ack_last_q));
    end
  endtask

  task automatic test_miss();
    clear_mon();
    pay_q.delete();
    for (int i = 0; i < 20; i++) pay_q.push_back(8'(i + 1));
    send_hdr(16'd4325);
    send_payload(1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (out_data_q.size() !== 0 || ack_hdr_cnt !== 0 || ack_q.size() !== 0) begin
      miscompares++;
      $display("FAIL miss_high_silent: got out %0d ack_hdr %0d ack_bytes %0d required 0 0 0",
               out_data_q.size(), ack_hdr_cnt, ack_q.size());
    end
    vectors++;
    if (drop_count !== 32'd1) begin
      miscompares++;
      $display("FAIL miss_high_drop_count: got %0d required 1", drop_count);
    end
    @(negedge clk);
    vectors++;
    if (rx_hdr.hdr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL miss_next_hdr_ready: got %b required 1", rx_hdr.hdr_ready);
    end
    @(posedge clk); #1;
    pay_q = '{8'h10, 8'h20, 8'h30};
    send_hdr(16'd4320);
    send_payload(1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (drop_count !== 32'd2 || out_data_q.size() !== 0 || ack_hdr_cnt !== 0) begin
      miscompares++;
      $display("FAIL miss_low: got drop %0d out %0d ack_hdr %0d required 2 0 0",
               drop_count, out_data_q.size(), ack_hdr_cnt);
    end
  endtask

  task automatic test_short();
    logic [127:0] got;
    clear_mon();
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_hdr(16'd4321);
    send_payload(1'b1, 1'b0);
    wait_ack();
    got = pack_bytes(ack_q);
    vectors++;
    if (out_data_q.size() !== 0) begin
      miscompares++;
      $display("FAIL short_out_beats: got %0d required 0", out_data_q.size());
    end
    vectors++;
    if (ack_q.size() !== 9 || got[71:40] !== 32'h11223344 || got[23:0] !== 24'h010000) begin
      miscompares++;
      $display("FAIL short_ack_payload: got %0d bytes %h required 11223344....010000",
               ack_q.size(), got);
    end
    vectors++;
    if (ack_hdr_word[79:48] !== {16'd4321, 16'd5000}) begin
      miscompares++;
      $display("FAIL short_ack_ports: got %h required %h", ack_hdr_word[79:48], {16'd4321, 16'd5000});
    end
  endtask

  task automatic test_rx_err();
    clear_mon();
    out_ready_mode = 1'b1;
    pay_q = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
              8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    send_hdr(16'd4324);
    send_payload(1'b1, 1'b1);
    wait_ack();
    out_ready_mode = 1'b0;
    vectors++;
    if (out_data_q.size() !== 7 || pack_bytes(out_data_q) !== 128'h31323334353637) begin
      miscompares++;
      $display("FAIL err_out_data: got %0d bytes %h required 7 bytes 31323334353637",
               out_data_q.size(), pack_bytes(out_data_q));
    end
    vectors++;
    if (pack_bits(out_last_q) !== 32'h1 || pack_bits(out_user_q) !== 32'h1) begin
      miscompares++;
      $display("FAIL err_out_flags: got tlast %b tuser %b required final beat only",
               pack_bits(out_last_q), pack_bits(out_user_q));
    end
    vectors++;
    if (out_dest_q.size() == 0 || out_dest_q.min() != '{4'd3} || out_dest_q.max() != '{4'd3}) begin
      miscompares++;
      $display("FAIL err_out_tdest: got beats not all tdest 3 (%0d beats), required 3", out_dest_q.size());
    end
    vectors++;
    if (pack_bytes(ack_q) !== 128'h0A0B0C0D0E0F020700) begin
      miscompares++;
      $display("FAIL err_ack_payload: got %h required 0a0b0c0d0e0f020700", pack_bytes(ack_q));
    end
  endtask

  task automatic test_tx_stall();
    bit seen;
    clear_mon();
    tx_hdr.hdr_ready = 1'b0;
    tx_pay.tready    = 1'b0;
    pay_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h55, 8'h66, 8'h77};
    send_hdr(16'd4323);
    send_payload(1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = tx_hdr.hdr_valid;
    end
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (tx_hdr.hdr_valid !== 1'b1 || {tx_hdr.src_port, tx_hdr.dst_port, tx_hdr.length}
          !== {16'd4323, 16'd5000, 16'd17}) begin
        miscompares++;
        $display("FAIL stall_hdr cycle %0d: got valid %b ports/len %h required 1 10e313880011",
                 c, tx_hdr.hdr_valid, {tx_hdr.src_port, tx_hdr.dst_port, tx_hdr.length});
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    tx_hdr.hdr_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = tx_pay.tvalid;
    end
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (tx_pay.tvalid !== 1'b1 || tx_pay.tdata !== 8'h21 || tx_pay.tlast !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_payload cycle %0d: got valid %b data %h last %b required 1 21 0",
                 c, tx_pay.tvalid, tx_pay.tdata, tx_pay.tlast);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    tx_pay.tready = 1'b1;
    wait_ack();
    vectors++;
    if (ack_hdr_cnt !== 1 || pack_bytes(ack_q) !== 128'h212223242526000300) begin
      miscompares++;
      $display("FAIL stall_ack: got hdrs %0d payload %h required 1 212223242526000300",
               ack_hdr_cnt, pack_bytes(ack_q));
    end
    vectors++;
    if (pack_bytes(out_data_q) !== 128'h556677) begin
      miscompares++;
      $display("FAIL stall_out_data: got %h required 556677", pack_bytes(out_data_q));
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h77, 8'h88, 8'h99};
    send_hdr(16'd4321);
    send_payload(1'b0, 1'b0);
    rx_pay.tvalid = 1'b1;
    rx_pay.tdata  = 8'hAA;
    reset = 1'b1;
    @(posedge clk); #1;
    rx_pay.tvalid = 1'b0;
    vectors++;
    if ({out_axis.tvalid, tx_hdr.hdr_valid, tx_pay.tvalid, rx_pay.tready} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_mid_valids: got out/hdr/ack valid, rx tready=%b required 0000",
               {out_axis.tvalid, tx_hdr.hdr_valid, tx_pay.tvalid, rx_pay.tready});
    end
    vectors++;
    if (drop_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_drop_count: got %0d required 0", drop_count);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (rx_hdr.hdr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_hdr_ready: got %b required 1", rx_hdr.hdr_ready);
    end
    @(posedge clk); #1;
    clear_mon();
    pay_q = '{8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'hC1, 8'hC2};
    send_hdr(16'd4323);
    send_payload(1'b1, 1'b0);
    wait_ack();
    vectors++;
    if (pack_bytes(out_data_q) !== 128'hC1C2 || pack_bits(out_last_q) !== 32'h1) begin
      miscompares++;
      $display("FAIL reset_mid_fresh_out: got %h last %b required c1c2 last on 2nd",
               pack_bytes(out_data_q), pack_bits(out_last_q));
    end
    vectors++;
    if (ack_hdr_cnt !== 1 || pack_bytes(ack_q) !== 128'h1A1B1C1D1E1F000200) begin
      miscompares++;
      $display("FAIL reset_mid_fresh_ack: got hdrs %0d payload %h required 1 1a1b1c1d1e1f000200",
               ack_hdr_cnt, pack_bytes(ack_q));
    end
  endtask

  initial begin
    rx_hdr.hdr_valid = 1'b0;
    rx_hdr.src_ip = '0; rx_hdr.dst_ip = '0; rx_hdr.src_port = '0; rx_hdr.dst_port = '0;
    rx_pay.tvalid = 1'b0; rx_pay.tdata = '0; rx_pay.tlast = 1'b0;
    rx_pay.tuser  = 1'b0; rx_pay.tdest = '0;
    tx_hdr.hdr_ready = 1'b1;
    tx_pay.tready    = 1'b1;
    clear_mon();
    test_reset();
    test_basic();
    test_miss();
    test_short();
    test_rx_err();
    test_tx_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
